alici_encoder: RTL
==================

Name: alici_encoder

Overview:
- Receive-side counterpart of the transmit chain: a parallel N-bit word is captured on basla, passed through a bit-serial encoder stage selected by mod1, then through an alici (receiver) post-processing stage selected by mod2.
- Result is presented on cikan_veri with a one-cycle bitti pulse.
- Single self-contained FSM with internal datapath; no submodules required.

Parameters:
- N, 30, data word width in bits (N >= 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- basla  input  1  start request; sampled only in IDLE.
- mod1  input  1  encoder select: 0 = Gray encode, 1 = bit reversal.
- mod2  input  1  alici select: 0 = pass-through, 1 = two's-complement negate.
- gelen_veri  input  N  input word; sampled with basla.
- cikan_veri  output  N  result word; registered, holds until the next completion.
- bitti  output  1  one-cycle pulse; cikan_veri is valid in the same cycle.
- mesgul  output  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, cikan_veri=0, bitti=0, mesgul=0, all internal registers 0.
- Reset has priority over everything; reset mid-operation aborts to IDLE with no bitti and clears cikan_veri.
- States: IDLE, ENC, RX, DONE-write folded into the last RX edge (bitti is a registered pulse).
- IDLE:
  - On edge with basla=1: capture gelen_veri into v, mod1 into m1, mod2 into m2; clear work register w; bit counter i=N-1; go to ENC.
  - Mod inputs are never re-sampled after this edge; later changes on mod1/mod2/gelen_veri have no effect on the current operation.
- ENC: one bit per edge, MSB first, exactly N edges (i = N-1 down to 0).
  - m1=0 (Gray encode): w[i] = v[i] ^ v[i+1], with v[N] treated as 0.
  - m1=1 (bit reversal): w[i] = v[N-1-i].
  - After the edge processing i=0: go to RX, reset the carry c=1 and counter j=0.
- RX:
  - m2=0: one edge; cikan_veri <= w; bitti <= 1; go to IDLE.
  - m2=1: bit-serial negation, LSB first, exactly N edges (j = 0 to N-1).
    - r[j] = ~w[j] ^ c.
    - c <= ~w[j] & c.
    - On the edge processing j=N-1: cikan_veri <= r with bit N-1 included; bitti <= 1; go to IDLE.
  - Final carry is discarded (arithmetic modulo 2^N); negating 0 gives 0.
- bitti: high for exactly one cycle, then 0; never asserted in the cycle after reset.
- Latency from the basla cycle to the bitti cycle: N+1 cycles when m2=0, 2N cycles when m2=1.
- Back-to-back operation: basla may be asserted in the same cycle bitti is high. The FSM is in IDLE then, so the request is accepted.
- Ignored requests:
  - basla while mesgul=1 is ignored, not queued, and has no side effects.
  - Repeated basla in IDLE after a completion starts a new operation normally.
- cikan_veri changes only on a completing edge or on reset.

Test Plan:
- N=8, gelen_veri=8'hB4, mod1=0, mod2=0 -> bitti 9 cycles after basla, cikan_veri=8'hEE, mesgul high for 9 cycles.
- N=8, 8'hB4, mod1=0, mod2=1 -> bitti after 16 cycles, cikan_veri=8'h12.
- N=8, 8'hB4, mod1=1, mod2=1 -> reversal 8'h2D, negate -> cikan_veri=8'hD3. Toggling mod1/mod2/gelen_veri every cycle after basla does not change the result.
- N=8, 8'h00, mod1=0, mod2=1 -> cikan_veri=8'h00 (carry discarded); second basla issued in the bitti cycle with 8'hB4, mod1=1, mod2=0 -> next bitti 9 cycles later, cikan_veri=8'h2D.
- N=30 default, 30'h3FFFFFFF, mod1=0, mod2=0 -> cikan_veri=30'h20000000 after 31 cycles. Extra basla pulses mid-operation are ignored and produce exactly one bitti.
- Assert rst at ENC bit 3 of an N=8 run -> next cycle state IDLE, cikan_veri=0, bitti never pulses. A fresh basla then completes normally with the correct value.

Source files
------------

// File: rtl/alici_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : alici_encoder_if
// Description : Request/result bundle for alici_encoder. The master side
//               issues start requests with a data word and mode selects; the
//               slave side returns the result word, a done pulse and busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface alici_encoder_if #(
    parameter int N = 30
) ();
    logic         basla;
    logic         mod1;
    logic         mod2;
    logic [N-1:0] gelen_veri;
    logic [N-1:0] cikan_veri;
    logic         bitti;
    logic         mesgul;

    modport master (
        output basla,
        output mod1,
        output mod2,
        output gelen_veri,
        input  cikan_veri,
        input  bitti,
        input  mesgul
    );

    modport slave (
        input  basla,
        input  mod1,
        input  mod2,
        input  gelen_veri,
        output cikan_veri,
        output bitti,
        output mesgul
    );
endinterface
`default_nettype wire

// File: rtl/alici_encoder.sv
`default_nettype none
// ============================================================================
// Module      : alici_encoder
// Description : Captures an N-bit word, encodes it bit-serially (Gray or bit
//               reversal), then post-processes it bit-serially (pass-through
//               or two's-complement negate). Result is registered with a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module alici_encoder #(
    parameter int N = 30
) (
    input  logic              clk,
    input  logic              rst,
    alici_encoder_if.slave    bus
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        RX   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  v;
    logic          m1;
    logic          m2;
    logic [N-1:0]  w;
    logic [N-1:0]  r;
    logic [CW-1:0] i;
    logic [CW-1:0] j;
    logic          c;
    logic [N-1:0]  cikan_veri;
    logic          bitti;

    logic [N-1:0]  gray;
    logic [N-1:0]  rev;
    logic          enc_last;
    logic          rx_last;
    logic          neg_bit;

    // Gray code of the captured word; bit N-1 sees an implicit 0 above it.
    assign gray = v ^ (v >> 1);

    generate
        for (genvar k = 0; k < N; k++) begin : g_rev
            assign rev[k] = v[N-1-k];
        end
    endgenerate

    assign enc_last = (i == '0);
    assign rx_last  = (j == LAST);
    assign neg_bit  = ~w[j] ^ c;

    assign bus.cikan_veri = cikan_veri;
    assign bus.bitti      = bitti;
    assign bus.mesgul     = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture in IDLE, N encode edges, then 1 or N receive edges.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.basla) begin
                    state_nxt = ENC;
                end
            end
            ENC: begin
                if (enc_last) begin
                    state_nxt = RX;
                end
            end
            RX: begin
                if (!m2 || rx_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial encode (MSB first), serial negate (LSB first).
    always_ff @(posedge clk) begin
        if (rst) begin
            v          <= '0;
            m1         <= 1'b0;
            m2         <= 1'b0;
            w          <= '0;
            r          <= '0;
            i          <= '0;
            j          <= '0;
            c          <= 1'b0;
            cikan_veri <= '0;
            bitti      <= 1'b0;
        end else begin
            bitti <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.basla) begin
                        v  <= bus.gelen_veri;
                        m1 <= bus.mod1;
                        m2 <= bus.mod2;
                        w  <= '0;
                        r  <= '0;
                        i  <= LAST;
                        j  <= '0;
                    end
                end
                ENC: begin
                    w[i] <= m1 ? rev[i] : gray[i];
                    if (enc_last) begin
                        c <= 1'b1;
                        j <= '0;
                    end else begin
                        i <= i - ONE;
                    end
                end
                RX: begin
                    if (!m2) begin
                        cikan_veri <= w;
                        bitti      <= 1'b1;
                    end else begin
                        r[j] <= neg_bit;
                        c    <= ~w[j] & c;
                        if (rx_last) begin
                            // Top bit is folded in directly; the final carry is dropped.
                            cikan_veri <= {neg_bit, r[N-2:0]};
                            bitti      <= 1'b1;
                        end else begin
                            j <= j + ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
